// File: rtl/enemy_scheduler_pkg.sv
// Shared types and constants for the enemy slot scheduler.
// Holds the 37-bit slot record layout, FSM state encoding and per-type tables.
// No logic here; imported by the scheduler and its free-slot search.
package enemy_scheduler_pkg;

  // Record layout: {exist, y, x, hp, type, spd_cnt}
  localparam int ENEMY_W   = 37;
  localparam int EXIST_BIT = 36;
  localparam int Y_LSB     = 24;
  localparam int X_LSB     = 12;
  localparam int HP_LSB    = 5;
  localparam int TYPE_LSB  = 2;
  localparam int SPD_LSB   = 0;

  // Slot index width is fixed by the 3-bit hit_idx / rd_idx ports
  localparam int IDX_W = 3;

  typedef struct packed {
    logic        exist;
    logic [11:0] y;
    logic [11:0] x;
    logic [6:0]  hp;
    logic [2:0]  etype;
    logic [1:0]  spd_cnt;
  } enemy_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    ALLOC = 2'd2
  } state_t;

  // Pixels moved per step, indexed by enemy type
  localparam logic [3:0] STEP [8] = '{4'd1, 4'd8, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

  // Starting hit points, indexed by enemy type
  localparam logic [6:0] HP_INIT [8] = '{7'd10, 7'd20, 7'd30, 7'd40, 7'd50, 7'd60, 7'd80, 7'd100};

endpackage

// File: rtl/enemy_scheduler_free_slot_finder.sv
// Lowest-index free slot search over the slot exist vector.
// Purely combinational, zero latency.
// No handshake; found=0 means every slot is occupied.
module free_slot_finder
  import enemy_scheduler_pkg::*;
#(
  parameter int N_SLOT = 8
) (
  input  logic [N_SLOT-1:0] exist,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  // Scan from the top down so the lowest free index is the last one written
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N_SLOT - 1; i >= 0; i--) begin
      if (!exist[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enemy_scheduler.sv
// Enemy slot table with hit, per-frame movement sweep and spawn allocation.
// Hit: 1 cycle in IDLE; sweep: N_SLOT cycles; spawn: 1 ALLOC cycle; acks registered.
// Requesters hold req until ack; requests stall while a sweep or alloc is running.
module enemy_scheduler
  import enemy_scheduler_pkg::*;
#(
  parameter int          N_SLOT  = 8,
  parameter logic [11:0] X_SPAWN = 12'd600
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               clear_all,
  input  logic               spawn_req,
  input  logic [2:0]         spawn_type,
  input  logic [11:0]        spawn_y,
  output logic               spawn_ack,
  output logic               spawn_ok,
  input  logic               hit_req,
  input  logic [2:0]         hit_idx,
  input  logic [6:0]         hit_dmg,
  output logic               hit_ack,
  input  logic [2:0]         rd_idx,
  output logic [ENEMY_W-1:0] rd_data,
  output logic               kill_pulse,
  output logic               base_pulse,
  output logic [3:0]         enemy_count,
  output logic               busy,
  output logic               overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLOT - 1);

  enemy_t            slots [N_SLOT];
  logic [N_SLOT-1:0] exist_vec;
  logic [3:0]        live_cnt;
  logic [IDX_W-1:0]  free_idx;
  logic              free_found;
  state_t            state;
  logic [IDX_W-1:0]  sweep_idx;
  logic              pending;
  enemy_t            sw_new;
  logic              sw_base;
  logic              sweep_last;

  assign busy       = (state != IDLE);
  assign sweep_last = (state == SWEEP) && (sweep_idx == LAST_IDX);

  // Occupancy vector and live-enemy population
  always_comb begin
    exist_vec = '0;
    live_cnt  = '0;
    for (int i = 0; i < N_SLOT; i++) begin
      exist_vec[i] = slots[i].exist;
      live_cnt     = live_cnt + 4'(slots[i].exist);
    end
  end

  free_slot_finder #(.N_SLOT(N_SLOT)) u_finder (
    .exist (exist_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  // Next record for the slot being swept: speed counter, movement, base arrival
  always_comb begin
    sw_new  = slots[sweep_idx];
    sw_base = 1'b0;
    if (slots[sweep_idx].exist) begin
      sw_new.spd_cnt = slots[sweep_idx].spd_cnt + 2'd1;
      if (slots[sweep_idx].spd_cnt == 2'd3) begin
        if (slots[sweep_idx].x <= {8'd0, STEP[slots[sweep_idx].etype]}) begin
          sw_new.x     = '0;
          sw_new.exist = 1'b0;
          sw_base      = 1'b1;
        end else begin
          sw_new.x = slots[sweep_idx].x - {8'd0, STEP[slots[sweep_idx].etype]};
        end
      end
    end
  end

  // Control FSM, slot table (one write per cycle) and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sweep_idx   <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      spawn_ack   <= 1'b0;
      spawn_ok    <= 1'b0;
      hit_ack     <= 1'b0;
      kill_pulse  <= 1'b0;
      base_pulse  <= 1'b0;
      enemy_count <= '0;
      rd_data     <= '0;
      for (int i = 0; i < N_SLOT; i++) slots[i] <= '0;
    end else begin
      spawn_ack   <= 1'b0;
      spawn_ok    <= 1'b0;
      hit_ack     <= 1'b0;
      kill_pulse  <= 1'b0;
      base_pulse  <= 1'b0;
      enemy_count <= live_cnt;
      rd_data     <= slots[rd_idx];
      if (clear_all) begin
        // Scene change: wipe everything, abandon any sweep or allocation
        for (int i = 0; i < N_SLOT; i++) slots[i] <= '0;
        pending   <= 1'b0;
        state     <= IDLE;
        sweep_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            // The ack guard stops a still-held request from being served twice
            if (hit_req && !hit_ack) begin
              hit_ack <= 1'b1;
              if (slots[hit_idx].exist) begin
                if (hit_dmg >= slots[hit_idx].hp) begin
                  slots[hit_idx].exist <= 1'b0;
                  kill_pulse           <= 1'b1;
                end else begin
                  slots[hit_idx].hp <= slots[hit_idx].hp - hit_dmg;
                end
              end
            end else if (pending) begin
              state     <= SWEEP;
              sweep_idx <= '0;
            end else if (spawn_req && !spawn_ack) begin
              state <= ALLOC;
            end
          end
          SWEEP: begin
            slots[sweep_idx] <= sw_new;
            base_pulse       <= sw_base;
            if (sweep_idx == LAST_IDX) begin
              state   <= IDLE;
              pending <= 1'b0;
            end else begin
              sweep_idx <= sweep_idx + 1'b1;
            end
          end
          ALLOC: begin
            spawn_ack <= 1'b1;
            spawn_ok  <= free_found;
            if (free_found) begin
              slots[free_idx].exist   <= 1'b1;
              slots[free_idx].y       <= spawn_y;
              slots[free_idx].x       <= X_SPAWN;
              slots[free_idx].hp      <= HP_INIT[spawn_type];
              slots[free_idx].etype   <= spawn_type;
              slots[free_idx].spd_cnt <= 2'b00;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
        // A tick landing on the last sweep cycle starts a fresh frame, not an overrun
        if (frame_tick) begin
          if (pending && !sweep_last) overrun <= 1'b1;
          else                        pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_enemy_scheduler.sv
// Self-checking bench for enemy_scheduler with a slot-table reference model.
// Expected ack results are queued at stimulus time and popped on each ack.
// All comparisons pass through chk; one summary line at the end.
module tb_enemy_scheduler;
  import enemy_scheduler_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_tick;
  logic               clear_all;
  logic               spawn_req;
  logic [2:0]         spawn_type;
  logic [11:0]        spawn_y;
  logic               spawn_ack;
  logic               spawn_ok;
  logic               hit_req;
  logic [2:0]         hit_idx;
  logic [6:0]         hit_dmg;
  logic               hit_ack;
  logic [2:0]         rd_idx;
  logic [ENEMY_W-1:0] rd_data;
  logic               kill_pulse;
  logic               base_pulse;
  logic [3:0]         enemy_count;
  logic               busy;
  logic               overrun;

  always #5 clk = ~clk;

  enemy_scheduler #(.N_SLOT(8), .X_SPAWN(12'd600)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .clear_all   (clear_all),
    .spawn_req   (spawn_req),
    .spawn_type  (spawn_type),
    .spawn_y     (spawn_y),
    .spawn_ack   (spawn_ack),
    .spawn_ok    (spawn_ok),
    .hit_req     (hit_req),
    .hit_idx     (hit_idx),
    .hit_dmg     (hit_dmg),
    .hit_ack     (hit_ack),
    .rd_idx      (rd_idx),
    .rd_data     (rd_data),
    .kill_pulse  (kill_pulse),
    .base_pulse  (base_pulse),
    .enemy_count (enemy_count),
    .busy        (busy),
    .overrun     (overrun)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  enemy_t model [8];
  logic   exp_ok_q [$];
  logic   exp_kill_q [$];
  int     busy_cycles = 0;
  int     base_seen = 0;

  // Count busy cycles and base pulses on the falling edge
  always @(negedge clk) begin
    if (busy) busy_cycles++;
    if (base_pulse) base_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_free();
    for (int i = 0; i < 8; i++) if (!model[i].exist) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < 8; i++) if (model[i].exist) n++;
    return n;
  endfunction

  task automatic model_sweep(output int bases);
    bases = 0;
    for (int i = 0; i < 8; i++) begin
      if (model[i].exist) begin
        if (model[i].spd_cnt == 2'd3) begin
          if (model[i].x <= 12'(STEP[model[i].etype])) begin
            model[i].x     = '0;
            model[i].exist = 1'b0;
            bases++;
          end else begin
            model[i].x = model[i].x - 12'(STEP[model[i].etype]);
          end
        end
        model[i].spd_cnt = model[i].spd_cnt + 2'd1;
      end
    end
  endtask

  task automatic model_hit(input int idx, input logic [6:0] dmg);
    logic k = 1'b0;
    if (model[idx].exist) begin
      if (dmg >= model[idx].hp) begin
        model[idx].exist = 1'b0;
        k = 1'b1;
      end else begin
        model[idx].hp = model[idx].hp - dmg;
      end
    end
    exp_kill_q.push_back(k);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  task automatic queue_spawn(input logic [2:0] t, input logic [11:0] y);
    int f = model_free();
    exp_ok_q.push_back(f >= 0);
    if (f >= 0) begin
      model[f]         = '0;
      model[f].exist   = 1'b1;
      model[f].y       = y;
      model[f].x       = 12'd600;
      model[f].hp      = HP_INIT[t];
      model[f].etype   = t;
      model[f].spd_cnt = 2'd0;
    end
  endtask

  task automatic read_slot(input int idx);
    rd_idx = 3'(idx);
    tick();
    chk($sformatf("slot%0d", idx), 64'(rd_data), 64'(model[idx]));
  endtask

  task automatic wait_spawn_ack();
    logic seen = 1'b0;
    logic e;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick();
      if (spawn_ack) seen = 1'b1;
    end
    chk("spawn_ack_seen", 64'(seen), 64'd1);
    e = exp_ok_q.pop_front();
    if (seen) chk("spawn_ok", 64'(spawn_ok), 64'(e));
    spawn_req = 1'b0;
  endtask

  task automatic do_spawn(input logic [2:0] t, input logic [11:0] y);
    queue_spawn(t, y);
    spawn_type = t;
    spawn_y    = y;
    spawn_req  = 1'b1;
    wait_spawn_ack();
  endtask

  task automatic do_hit(input int idx, input logic [6:0] dmg);
    logic seen = 1'b0;
    logic e;
    model_hit(idx, dmg);
    hit_idx = 3'(idx);
    hit_dmg = dmg;
    hit_req = 1'b1;
    for (int c = 0; c < 50 && !seen; c++) begin
      tick();
      if (hit_ack) seen = 1'b1;
    end
    chk("hit_ack_seen", 64'(seen), 64'd1);
    e = exp_kill_q.pop_front();
    if (seen) chk("kill_pulse", 64'(kill_pulse), 64'(e));
    hit_req = 1'b0;
  endtask

  task automatic do_frame(input string tag);
    int   exp_b;
    logic started = 1'b0;
    logic done = 1'b0;
    model_sweep(exp_b);
    busy_cycles = 0;
    base_seen   = 0;
    frame_tick  = 1'b1;
    tick();
    frame_tick = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (busy) started = 1'b1;
      else if (started) done = 1'b1;
    end
    tick();
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_len"}, 64'(busy_cycles), 64'd8);
    chk({tag, "_base"}, 64'(base_seen), 64'(exp_b));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   exp_b;
    int   first_idle;
    int   ack_c;
    logic seen;
    logic checked;
    logic e;
    logic [2:0]  fill_t [7] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    logic [11:0] fill_y [7] = '{12'd200, 12'd300, 12'd50, 12'd75, 12'd125, 12'd250, 12'd400};

    rst = 1'b1; frame_tick = 1'b0; clear_all = 1'b0;
    spawn_req = 1'b0; spawn_type = '0; spawn_y = '0;
    hit_req = 1'b0; hit_idx = '0; hit_dmg = '0; rd_idx = '0;
    model_clear();
    repeat (3) tick();

    // Reset state
    chk("rst_spawn_ack", 64'(spawn_ack), 64'd0);
    chk("rst_spawn_ok", 64'(spawn_ok), 64'd0);
    chk("rst_hit_ack", 64'(hit_ack), 64'd0);
    chk("rst_kill", 64'(kill_pulse), 64'd0);
    chk("rst_base", 64'(base_pulse), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_count", 64'(enemy_count), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b0;
    tick();

    // First spawn into an empty table
    do_spawn(3'd0, 12'd100);
    chk("count_at_ack", 64'(enemy_count), 64'd0);
    tick();
    chk("count_after_spawn", 64'(enemy_count), 64'd1);
    read_slot(0);
    chk("slot0_x", 64'(rd_data[X_LSB +: 12]), 64'd600);
    chk("slot0_hp", 64'(rd_data[HP_LSB +: 7]), 64'(HP_INIT[0]));

    // Fill the table, then a ninth spawn must be refused
    for (int i = 0; i < 7; i++) do_spawn(fill_t[i], fill_y[i]);
    for (int i = 0; i < 8; i++) read_slot(i);
    do_spawn(3'd7, 12'd50);
    for (int i = 0; i < 8; i++) read_slot(i);
    chk("count_full", 64'(enemy_count), 64'(model_count()));

    // Damage then kill slot 2 (hp 10), then a hit on the dead slot
    do_hit(2, 7'd4);
    read_slot(2);
    do_hit(2, 7'd6);
    read_slot(2);
    do_hit(2, 7'd1);
    read_slot(2);
    tick();
    chk("count_after_kill", 64'(enemy_count), 64'(model_count()));

    // Two ticks three cycles apart, hit raised mid-sweep
    model_sweep(exp_b);
    busy_cycles = 0;
    base_seen   = 0;
    frame_tick  = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
    tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("busy_when_hit_raised", 64'(busy), 64'd1);
    model_hit(0, 7'd1);
    hit_idx = 3'd0;
    hit_dmg = 7'd1;
    hit_req = 1'b1;
    first_idle = -1;
    ack_c = -1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (!busy && first_idle < 0) first_idle = c;
      if (hit_ack) begin
        seen  = 1'b1;
        ack_c = c;
      end
    end
    chk("midsweep_hit_ack_seen", 64'(seen), 64'd1);
    e = exp_kill_q.pop_front();
    chk("midsweep_kill", 64'(kill_pulse), 64'(e));
    chk("midsweep_ack_lag", 64'(ack_c - first_idle), 64'd1);
    hit_req = 1'b0;
    repeat (4) tick();
    chk("overrun_set", 64'(overrun), 64'd1);
    chk("overrun_sweep_len", 64'(busy_cycles), 64'd8);
    chk("overrun_base", 64'(base_seen), 64'(exp_b));
    for (int i = 0; i < 8; i++) read_slot(i);

    // clear_all mid-sweep while a spawn is held
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (busy) seen = 1'b1;
    end
    chk("clear_sweep_started", 64'(seen), 64'd1);
    tick();
    tick();
    spawn_type = 3'd2;
    spawn_y    = 12'd77;
    spawn_req  = 1'b1;
    clear_all  = 1'b1;
    tick();
    clear_all = 1'b0;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_no_ack", 64'(spawn_ack), 64'd0);
    model_clear();
    queue_spawn(3'd2, 12'd77);
    wait_spawn_ack();
    busy_cycles = 0;
    repeat (12) tick();
    chk("no_resumed_sweep", 64'(busy_cycles), 64'd0);
    chk("overrun_sticky", 64'(overrun), 64'd1);
    for (int i = 0; i < 8; i++) read_slot(i);

    // Type-1 enemy walks to the base
    do_spawn(3'd1, 12'd400);
    checked = 1'b0;
    for (int f = 0; f < 400 && model[1].exist; f++) begin
      do_frame("frame");
      if (!checked && model[1].exist && model[1].x == 12'(STEP[1]) && model[1].spd_cnt == 2'd0) begin
        read_slot(1);
        checked = 1'b1;
      end
    end
    chk("x_at_step_observed", 64'(checked), 64'd1);
    chk("base_pulse_last_sweep", 64'(base_seen), 64'd1);
    read_slot(1);
    chk("base_exist", 64'(rd_data[EXIST_BIT]), 64'd0);
    chk("base_x", 64'(rd_data[X_LSB +: 12]), 64'd0);
    read_slot(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
